// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready command-to-ALU sequencer with fixed-latency result capture. Rev 1.0
// Optional macro ALU_SEQ_CHAIN_EN adds cmd_chain, which substitutes the last captured result for operand A.
`default_nettype none

module alu_op_sequencer #(
  parameter int WIDTH   = 5,
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_op,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic             cmd_chain,
`endif
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_op,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_cf,
  input  logic             alu_sf,
  input  logic             alu_zf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_r,
  output logic             rsp_cf,
  output logic             rsp_sf,
  output logic             rsp_zf,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
);

  localparam logic [3:0] C_LAT_M1 = 4'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [WIDTH-1:0]   alu_b_q, alu_b_d;
  logic               alu_op_q, alu_op_d;
  logic [3:0]         wait_q, wait_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_r_q, rsp_r_d;
  logic               rsp_cf_q, rsp_cf_d;
  logic               rsp_sf_q, rsp_sf_d;
  logic               rsp_zf_q, rsp_zf_d;
  logic [CNT_W-1:0]   op_count_q, op_count_d;
  logic [WIDTH-1:0]   w_operand_a;

  // rsp_r_q doubles as the chain source: it always holds the most recent capture.
`ifdef ALU_SEQ_CHAIN_EN
  assign w_operand_a = cmd_chain ? rsp_r_q : cmd_a;
`else
  assign w_operand_a = cmd_a;
`endif

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    wait_d      = wait_q;
    rsp_valid_d = rsp_valid_q;
    rsp_r_d     = rsp_r_q;
    rsp_cf_d    = rsp_cf_q;
    rsp_sf_d    = rsp_sf_q;
    rsp_zf_d    = rsp_zf_q;
    op_count_d  = op_count_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          alu_a_d  = w_operand_a;
          alu_b_d  = cmd_b;
          alu_op_d = cmd_op;
          wait_d   = C_LAT_M1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_q == 4'd0) begin
          rsp_r_d     = alu_r;
          rsp_cf_d    = alu_cf;
          rsp_sf_d    = alu_sf;
          rsp_zf_d    = alu_zf;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= 1'b0;
      wait_q      <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_r_q     <= '0;
      rsp_cf_q    <= 1'b0;
      rsp_sf_q    <= 1'b0;
      rsp_zf_q    <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      wait_q      <= wait_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_r_q     <= rsp_r_d;
      rsp_cf_q    <= rsp_cf_d;
      rsp_sf_q    <= rsp_sf_d;
      rsp_zf_q    <= rsp_zf_d;
      op_count_q  <= op_count_d;
    end
  end

  // Handshake qualifiers depend on state only, never on the peer's valid/ready.
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_r     = rsp_r_q;
  assign rsp_cf    = rsp_cf_q;
  assign rsp_sf    = rsp_sf_q;
  assign rsp_zf    = rsp_zf_q;
  assign op_count  = op_count_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench for alu_op_sequencer with an arithmetic reference model.
// Builds with or without ALU_SEQ_CHAIN_EN.
`default_nettype none

module tb_alu_op_sequencer;

  localparam int WIDTH   = 5;
  localparam int ALU_LAT = 1;
  localparam int CNT_W   = 2;
`ifdef ALU_SEQ_CHAIN_EN
  localparam bit CHAIN_EN = 1'b1;
`else
  localparam bit CHAIN_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a = '0;
  logic [WIDTH-1:0] cmd_b = '0;
  logic             cmd_op = 1'b0;
  logic             cmd_chain = 1'b0;
  logic [WIDTH-1:0] alu_a, alu_b, alu_r;
  logic             alu_op, alu_cf, alu_sf, alu_zf;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_r;
  logic             rsp_cf, rsp_sf, rsp_zf;
  logic [CNT_W-1:0] op_count;
  logic             busy;

  alu_op_sequencer #(.WIDTH(WIDTH), .ALU_LAT(ALU_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
`ifdef ALU_SEQ_CHAIN_EN
    .cmd_chain(cmd_chain),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r(alu_r), .alu_cf(alu_cf), .alu_sf(alu_sf), .alu_zf(alu_zf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_r(rsp_r), .rsp_cf(rsp_cf), .rsp_sf(rsp_sf), .rsp_zf(rsp_zf),
    .op_count(op_count), .busy(busy)
  );

  // Combinational ALU the sequencer drives
  assign {alu_cf, alu_r} = alu_op ? ({1'b0, alu_a} - {1'b0, alu_b})
                                  : ({1'b0, alu_a} + {1'b0, alu_b});
  assign alu_sf = alu_r[WIDTH-1];
  assign alu_zf = (alu_r == '0);

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] r;
    logic             cf;
    logic             sf;
    logic             zf;
    int               acc_edge;
    bit               seen;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_r = 0;
  int   exp_cnt = 0;
  int   hs_edge = -10;
  int   acc_last = 0;
  bit   pending = 1'b0;
  int   rdy_mode = 2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input bit op);
    exp_t e;
    int   s;
    s      = op ? a - b : a + b;
    e.r    = s[WIDTH-1:0];
    e.cf   = op ? (a < b) : (s >= (1 << WIDTH));
    e.sf   = e.r[WIDTH-1];
    e.zf   = (e.r == '0);
    e.acc_edge = 0;
    e.seen = 1'b0;
    return e;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      check("op_count", 32'(op_count), 32'(exp_cnt));
      check("busy_vs_cmd_ready", 32'(busy), 32'(!cmd_ready));
      if (rsp_valid) begin
        check("rsp_has_cmd", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          if (!sb[0].seen) begin
            check("latency", 32'(cyc - sb[0].acc_edge), 32'(ALU_LAT));
            sb[0].seen = 1'b1;
          end
          check("rsp_r", 32'(rsp_r), 32'(sb[0].r));
          check("rsp_cf", 32'(rsp_cf), 32'(sb[0].cf));
          check("rsp_sf", 32'(rsp_sf), 32'(sb[0].sf));
          check("rsp_zf", 32'(rsp_zf), 32'(sb[0].zf));
          check("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
          if (rsp_ready) begin
            last_r  = int'(sb[0].r);
            void'(sb.pop_front());
            hs_edge = cyc + 1;
            exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
          end
        end
      end else begin
        check("rsp_r_retained", 32'(rsp_r), 32'(last_r));
      end
      if (cmd_valid) begin
        if (!cmd_ready) begin
          pending = 1'b1;
        end else begin
          exp_t e;
          if (pending) check("pending_accept_edge", 32'(cyc + 1), 32'(hs_edge + 1));
          pending    = 1'b0;
          e          = model((CHAIN_EN && cmd_chain) ? last_r : int'(cmd_a), int'(cmd_b), cmd_op);
          e.acc_edge = cyc + 1;
          acc_last   = cyc + 1;
          sb.push_back(e);
        end
      end
    end
  end

  // Response-side ready generator: 0 = always ready, 1 = random, 2 = stalled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ($urandom_range(0, 3) != 0);
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic op, input logic ch);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_chain = ch;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("cmd_accept_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_chain = 1'b0;
  endtask

  task automatic wait_rsp(input logic [WIDTH-1:0] r, input logic cf, input logic sf, input logic zf);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("rsp_timeout", 32'(found), 32'd1);
    check("dir_rsp_r", 32'(rsp_r), 32'(r));
    check("dir_rsp_cf", 32'(rsp_cf), 32'(cf));
    check("dir_rsp_sf", 32'(rsp_sf), 32'(sf));
    check("dir_rsp_zf", 32'(rsp_zf), 32'(zf));
  endtask

  task automatic clear_model();
    sb.delete();
    last_r  = 0;
    exp_cnt = 0;
    pending = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
    check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
    check({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_r"}, 32'(rsp_r), 32'd0);
    check({tag, "_flags"}, 32'({rsp_cf, rsp_sf, rsp_zf}), 32'd0);
    check({tag, "_op_count"}, 32'(op_count), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  int exp_tp[5] = '{1, 2, 3, 0, 1};

  initial begin
    int prev_acc;
    bit drained;
    #2;
    check_zero_outputs("reset");
    repeat (2) @(posedge clk);
    release_reset();
    rdy_mode = 0;

    // Add with carry, sign set
    send(5'b11100, 5'b11000, 1'b0, 1'b0);
    wait_rsp(5'b10100, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("op_count_after_add", 32'(op_count), 32'd1);

    // Subtract to zero
    send(5'b01110, 5'b01110, 1'b1, 1'b0);
    wait_rsp(5'b00000, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset while the operation is in WAIT
    send(5'b00111, 5'b00001, 1'b0, 1'b0);
    check("busy_before_abort", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    clear_model();
    check_zero_outputs("abort");
    release_reset();

    // Backpressure with a second command pending behind the stalled response
    rdy_mode = 2;
    @(posedge clk);
    send(5'b11100, 5'b00100, 1'b1, 1'b0);
    wait_rsp(5'b11000, 1'b0, 1'b1, 1'b0);
    fork
      send(5'b00001, 5'b00001, 1'b0, 1'b0);
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
          check("bp_rsp_r_hold", 32'(rsp_r), 32'(5'b11000));
          check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rdy_mode = 0;
      end
    join
    wait_rsp(5'b00010, 1'b0, 1'b0, 1'b0);

    // Back-to-back throughput and op_count wrap from a clean reset
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    clear_model();
    release_reset();
    prev_acc = 0;
    for (int i = 0; i < 5; i++) begin
      send(5'($urandom), 5'($urandom), 1'($urandom), 1'b0);
      if (i > 0) begin
        check("tp_spacing", 32'(acc_last - prev_acc), 32'(ALU_LAT + 2));
        check("tp_op_count", 32'(op_count), 32'(exp_tp[i-1]));
      end
      prev_acc = acc_last;
    end
    wait_rsp(sb[0].r, sb[0].cf, sb[0].sf, sb[0].zf);
    @(negedge clk);
    check("tp_op_count_last", 32'(op_count), 32'(exp_tp[4]));

`ifdef ALU_SEQ_CHAIN_EN
    send(5'b00011, 5'b00010, 1'b0, 1'b0);
    wait_rsp(5'b00101, 1'b0, 1'b0, 1'b0);
    send(5'b11111, 5'b00001, 1'b0, 1'b1);
    wait_rsp(5'b00110, 1'b0, 1'b0, 1'b0);
`endif

    // Randomized traffic with random stalls and idle gaps
    rdy_mode = 1;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send(5'($urandom), 5'($urandom), 1'($urandom), CHAIN_EN ? 1'($urandom) : 1'b0);
    end
    rdy_mode = 0;

    drained = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rsp_valid) begin
        drained = 1'b1;
        break;
      end
    end
    check("drain", 32'(drained), 32'd1);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
